// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC sequencer with taken-branch redirect and fixed-length flush
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_redirect_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        stall_pi,
  input  logic        halt_pi,
  input  logic        branch_resolve_pi,
  input  logic        is_branch_taken_pi,
  input  logic [15:0] branch_target_pi,
  output logic [15:0] pc_po,
`ifdef BRANCH_STATS_EN
  output logic [15:0] branch_count_po,
  output logic [15:0] taken_count_po,
`endif
  output logic        fetch_valid_po,
  output logic        flush_po,
  output logic        halted_po
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] flush_cnt;
  logic       taken_now;

  assign taken_now = branch_resolve_pi & is_branch_taken_pi;

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state          <= BOOT;
      pc_po          <= RESET_PC;
      fetch_valid_po <= 1'b0;
      flush_po       <= 1'b0;
      halted_po      <= 1'b0;
      flush_cnt      <= 3'd0;
    end else begin
      case (state)
        BOOT: begin
          state          <= RUN;
          fetch_valid_po <= 1'b1;
        end
        RUN: begin
          // A taken branch outranks stall/halt: those come from wrong-path instructions.
          if (taken_now) begin
            state          <= FLUSH;
            pc_po          <= branch_target_pi;
            flush_po       <= 1'b1;
            fetch_valid_po <= 1'b0;
            flush_cnt      <= FLUSH_LAST;
          end else if (halt_pi) begin
            state          <= HALT;
            halted_po      <= 1'b1;
            fetch_valid_po <= 1'b0;
          end else if (!stall_pi) begin
            pc_po <= pc_po + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state          <= RUN;
            flush_po       <= 1'b0;
            fetch_valid_po <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      branch_count_po <= 16'd0;
      taken_count_po  <= 16'd0;
    end else if (state == RUN) begin
      if (branch_resolve_pi && (branch_count_po != 16'hFFFF))
        branch_count_po <= branch_count_po + 16'd1;
      if (taken_now && (taken_count_po != 16'hFFFF))
        taken_count_po <= taken_count_po + 16'd1;
    end
  end
`endif

endmodule
